// File: rtl/dmi_jtag_txn_engine.sv
// TCK-domain DMI transaction engine: owns the DMI data register, issues requests to the
// DMI CDC, waits for responses and keeps the sticky DTMCS.dmistat error.
module dmi_jtag_txn_engine #(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 test_logic_reset_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_access_i,
  input  logic                 dtmcs_select_i,
  input  logic                 dmi_reset_i,
  input  logic                 dmi_hard_reset_i,
  input  logic                 dmi_tdi_i,
  output logic                 dmi_tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [31:0]          req_data_o,
  output logic [1:0]           req_op_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  input  logic [31:0]          resp_data_i,
  input  logic [1:0]           resp_status_i,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o
);

  localparam int unsigned DrWidth    = AddrWidth + 34;
  localparam int unsigned TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit          TimeoutEn  = (TimeoutCycles != 0);
  localparam logic [TimerWidth-1:0] TimerMax =
    TimerWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

  localparam logic [2:0] Idle  = 3'd0;
  localparam logic [2:0] Read  = 3'd1;
  localparam logic [2:0] WaitR = 3'd2;
  localparam logic [2:0] Write = 3'd3;
  localparam logic [2:0] WaitW = 3'd4;
  localparam logic [2:0] Drain = 3'd5;

  localparam logic [1:0] ErrNone   = 2'd0;
  localparam logic [1:0] ErrFailed = 2'd2;
  localparam logic [1:0] ErrBusy   = 2'd3;

  logic [2:0]            state_q, state_d;
  logic [DrWidth-1:0]    dr_q, dr_d;
  logic [AddrWidth-1:0]  address_q, address_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            error_q, error_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  req_valid_q, req_valid_d;
  logic [1:0]            req_op_q, req_op_d;

  logic dmi_update, dtmcs_update, hard_reset, busy, op_failed, timed_out;

  // Next-state, datapath and error computation
  always_comb begin
    state_d    = state_q;
    dr_d       = dr_q;
    address_d  = address_q;
    data_d     = data_q;
    error_d    = error_q;
    timer_d    = timer_q;
    op_failed  = 1'b0;
    dmi_update   = update_dr_i & dmi_access_i;
    dtmcs_update = update_dr_i & dtmcs_select_i;
    hard_reset   = dtmcs_update & dmi_hard_reset_i;
    busy       = (dmi_update & (state_q != Idle)) |
                 (capture_dr_i & dmi_access_i & ((state_q == Read) | (state_q == WaitR)));
    timed_out  = TimeoutEn && (timer_q == TimerMax);

    case (state_q)
      Idle: begin
        if (dmi_update && (error_q == ErrNone)) begin
          address_d = dr_q[DrWidth-1:34];
          data_d    = dr_q[33:2];
          if (dr_q[1:0] == 2'd1)      state_d = Read;
          else if (dr_q[1:0] == 2'd2) state_d = Write;
        end
      end
      Read, Write: begin
        if (req_ready_i) begin
          state_d = (state_q == Read) ? WaitR : WaitW;
          timer_d = '0;
        end
      end
      WaitR, WaitW: begin
        timer_d = timer_q + TimerWidth'(1);
        if (resp_valid_i) begin
          if (state_q == WaitR) data_d = resp_data_i;
          op_failed = (resp_status_i != 2'd0);
          state_d   = Idle;
        end else if (timed_out) begin
          op_failed = 1'b1;
          state_d   = Drain;
        end
      end
      Drain: begin
        if (resp_valid_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase

    // Hard reset withdraws a pending request; an outstanding one must still be drained
    if (hard_reset) begin
      if ((state_q == Read) || (state_q == Write)) begin
        state_d = Idle;
      end else if ((state_q == WaitR) || (state_q == WaitW)) begin
        state_d = Drain;
        data_d  = data_q;
      end
    end

    if (op_failed && (error_q == ErrNone)) error_d = ErrFailed;
    if (busy) error_d = ErrBusy;
    if (dtmcs_update && (dmi_reset_i || dmi_hard_reset_i)) error_d = ErrNone;

    if (test_logic_reset_i) begin
      dr_d = '0;
    end else if (dmi_access_i) begin
      if (capture_dr_i) begin
        dr_d = {address_q, data_q, (busy || (error_q == ErrBusy)) ? ErrBusy : error_q};
      end else if (shift_dr_i) begin
        dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]};
      end
    end

    req_valid_d = (state_d == Read) || (state_d == Write);
    req_op_d    = (state_d == Read) ? 2'd1 : ((state_d == Write) ? 2'd2 : 2'd0);
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q     <= Idle;
      dr_q        <= '0;
      address_q   <= '0;
      data_q      <= '0;
      error_q     <= ErrNone;
      timer_q     <= '0;
      req_valid_q <= 1'b0;
      req_op_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      dr_q        <= dr_d;
      address_q   <= address_d;
      data_q      <= data_d;
      error_q     <= error_d;
      timer_q     <= timer_d;
      req_valid_q <= req_valid_d;
      req_op_q    <= req_op_d;
    end
  end

  assign dmi_tdo_o    = dr_q[0];
  assign dmi_error_o  = error_q;
  assign req_addr_o   = address_q;
  assign req_data_o   = data_q;
  assign req_op_o     = req_op_q;
  assign req_valid_o  = req_valid_q;
  assign resp_ready_o = 1'b1;

endmodule

// File: tb/tb_dmi_jtag_txn_engine.sv
// Bench for dmi_jtag_txn_engine: a 7-bit/1024-cycle instance and a 12-bit/16-cycle instance
// share one TAP driver; sel routes IR selection and handshakes to one of them.
module tb_dmi_jtag_txn_engine;

  localparam int unsigned AwA = 7;
  localparam int unsigned AwB = 12;
  localparam int unsigned NA  = AwA + 34;
  localparam int unsigned NB  = AwB + 34;

  logic tck = 1'b0;
  logic trst_n;
  logic tlr, cdr, sdr, udr, acc, dtm, dmir, dmih, tdi, sel;
  logic req_ready, resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;

  logic tdo_a, tdo_b, valid_a, valid_b, rr_a, rr_b;
  logic [1:0] err_a, err_b, op_a, op_b;
  logic [AwA-1:0] addr_a;
  logic [AwB-1:0] addr_b;
  logic [31:0] data_a, data_b;

  logic        tdo_m, valid_m;
  logic [1:0]  err_m, op_m;
  logic [31:0] addr_m, data_m;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  dmi_jtag_txn_engine #(.AddrWidth(AwA), .TimeoutCycles(1024)) dut_a (
    .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
    .capture_dr_i(cdr), .shift_dr_i(sdr), .update_dr_i(udr),
    .dmi_access_i(acc & ~sel), .dtmcs_select_i(dtm & ~sel),
    .dmi_reset_i(dmir), .dmi_hard_reset_i(dmih), .dmi_tdi_i(tdi),
    .dmi_tdo_o(tdo_a), .dmi_error_o(err_a),
    .req_addr_o(addr_a), .req_data_o(data_a), .req_op_o(op_a), .req_valid_o(valid_a),
    .req_ready_i(req_ready & ~sel), .resp_data_i(resp_data), .resp_status_i(resp_status),
    .resp_valid_i(resp_valid & ~sel), .resp_ready_o(rr_a)
  );

  dmi_jtag_txn_engine #(.AddrWidth(AwB), .TimeoutCycles(16)) dut_b (
    .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
    .capture_dr_i(cdr), .shift_dr_i(sdr), .update_dr_i(udr),
    .dmi_access_i(acc & sel), .dtmcs_select_i(dtm & sel),
    .dmi_reset_i(dmir), .dmi_hard_reset_i(dmih), .dmi_tdi_i(tdi),
    .dmi_tdo_o(tdo_b), .dmi_error_o(err_b),
    .req_addr_o(addr_b), .req_data_o(data_b), .req_op_o(op_b), .req_valid_o(valid_b),
    .req_ready_i(req_ready & sel), .resp_data_i(resp_data), .resp_status_i(resp_status),
    .resp_valid_i(resp_valid & sel), .resp_ready_o(rr_b)
  );

  assign tdo_m   = sel ? tdo_b : tdo_a;
  assign valid_m = sel ? valid_b : valid_a;
  assign err_m   = sel ? err_b : err_a;
  assign op_m    = sel ? op_b : op_a;
  assign addr_m  = sel ? 32'(addr_b) : 32'(addr_a);
  assign data_m  = sel ? data_b : data_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_dr(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] op);
    return (64'(a) << 34) | (64'(d) << 2) | 64'(op);
  endfunction

  // Capture, shift the full DR LSB first (collecting TDO), then update
  task automatic scan(input logic [63:0] val, output logic [63:0] captured);
    int n;
    n = sel ? int'(NB) : int'(NA);
    captured = '0;
    acc = 1'b1; cdr = 1'b1;
    @(negedge tck);
    cdr = 1'b0; sdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      captured[i] = tdo_m;
      tdi = val[i];
      @(negedge tck);
    end
    sdr = 1'b0; tdi = 1'b0; udr = 1'b1;
    @(negedge tck);
    udr = 1'b0;
  endtask

  task automatic dtmcs_write(input logic rst, input logic hard);
    acc = 1'b0; dtm = 1'b1; dmir = rst; dmih = hard; udr = 1'b1;
    @(negedge tck);
    udr = 1'b0; dtm = 1'b0; dmir = 1'b0; dmih = 1'b0; acc = 1'b1;
  endtask

  task automatic respond(input logic [31:0] rd, input logic [1:0] st);
    resp_data = rd; resp_status = st; resp_valid = 1'b1;
    @(negedge tck);
    resp_valid = 1'b0; resp_status = 2'd0; resp_data = '0;
  endtask

  // Request must be presented and held until ready, then dropped; then reply
  task automatic serve(input int rdly, input int wdly, input logic [31:0] rd, input logic [1:0] st,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [1:0] eop);
    chk("req_valid", 64'(valid_m), 64'd1);
    chk("req_addr", 64'(addr_m), 64'(ea));
    chk("req_data", 64'(data_m), 64'(ed));
    chk("req_op", 64'(op_m), 64'(eop));
    for (int i = 0; i < rdly; i++) begin
      @(negedge tck);
      chk("req_valid_hold", 64'(valid_m), 64'd1);
    end
    req_ready = 1'b1;
    @(negedge tck);
    req_ready = 1'b0;
    chk("req_valid_drop", 64'(valid_m), 64'd0);
    repeat (wdly) @(negedge tck);
    respond(rd, st);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [1:0] op, input logic [1:0] st, input logic issue,
                     input int rdly, input int wdly, output logic [63:0] c);
    scan(mk_dr(a, wd, op), c);
    if (issue) begin
      serve(rdly, wdly, rd, st, a, wd, op);
    end else begin
      repeat (2) begin
        chk("no_request", 64'(valid_m), 64'd0);
        @(negedge tck);
      end
    end
    @(negedge tck);
  endtask

  typedef struct {
    logic        clr;
    logic [1:0]  op;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  st;
    logic        exp_issue;
    logic [63:0] exp_cap;
    logic [1:0]  exp_err;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [63:0] c;
    logic [31:0] m_addr, m_data, ra, rw, rr;
    logic [1:0]  m_err, rop, rst;
    logic        issue;

    tbl[0] = '{1'b0, 2'd1, 32'h11, 32'h0,        32'hDEADBEEF, 2'd0, 1'b1, 64'd0, 2'd0};
    tbl[1] = '{1'b0, 2'd0, 32'h7F, 32'hFFFFFFFF, 32'h0,        2'd0, 1'b0,
               mk_dr(32'h11, 32'hDEADBEEF, 2'd0), 2'd0};
    tbl[2] = '{1'b0, 2'd2, 32'h05, 32'h0000A5A5, 32'h11111111, 2'd2, 1'b1,
               mk_dr(32'h7F, 32'hFFFFFFFF, 2'd0), 2'd2};
    tbl[3] = '{1'b0, 2'd1, 32'h06, 32'h0,        32'h22222222, 2'd0, 1'b0,
               mk_dr(32'h05, 32'h0000A5A5, 2'd2), 2'd2};
    tbl[4] = '{1'b1, 2'd1, 32'h06, 32'h0,        32'h0BADF00D, 2'd0, 1'b1,
               mk_dr(32'h05, 32'h0000A5A5, 2'd0), 2'd0};
    tbl[5] = '{1'b0, 2'd3, 32'h00, 32'h0,        32'h0,        2'd0, 1'b0,
               mk_dr(32'h06, 32'h0BADF00D, 2'd0), 2'd0};

    {tlr, cdr, sdr, udr, acc, dtm, dmir, dmih, tdi, sel, req_ready, resp_valid} = '0;
    resp_data = '0; resp_status = 2'd0;
    trst_n = 1'b0;
    repeat (3) @(negedge tck);
    chk("rst_tdo_a", 64'(tdo_a), 64'd0);
    chk("rst_valid_a", 64'(valid_a), 64'd0);
    chk("rst_err_a", 64'(err_a), 64'd0);
    chk("rst_valid_b", 64'(valid_b), 64'd0);
    chk("rst_resp_ready", 64'({rr_a, rr_b}), 64'd3);
    trst_n = 1'b1;
    @(negedge tck);

    // Directed transaction table on the 7-bit instance
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr) dtmcs_write(1'b1, 1'b0);
      txn(tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].op, tbl[i].st, tbl[i].exp_issue,
          2, 3, c);
      chk($sformatf("tbl%0d_cap", i), c, tbl[i].exp_cap);
      chk($sformatf("tbl%0d_err", i), 64'(err_m), 64'(tbl[i].exp_err));
    end

    // Write issued while a previous write still waits for its response
    scan(mk_dr(32'h05, 32'h1234, 2'd2), c);
    chk("t2_cap0", c, mk_dr(32'h0, 32'h0, 2'd0));
    chk("t2_valid", 64'(valid_m), 64'd1);
    req_ready = 1'b1; @(negedge tck); req_ready = 1'b0;
    scan(mk_dr(32'h06, 32'h5555, 2'd2), c);
    chk("t2_cap_waitw", c, mk_dr(32'h05, 32'h1234, 2'd0));
    chk("t2_err_busy", 64'(err_m), 64'd3);
    for (int i = 0; i < 6; i++) begin
      chk("t2_no_second_req", 64'(valid_m), 64'd0);
      @(negedge tck);
    end
    respond(32'h0, 2'd0);
    chk("t2_err_sticky", 64'(err_m), 64'd3);
    scan(mk_dr(32'h0, 32'h0, 2'd0), c);
    chk("t2_cap_st3", c, mk_dr(32'h05, 32'h1234, 2'd3));
    dtmcs_write(1'b1, 1'b0);
    chk("t2_err_clr", 64'(err_m), 64'd0);
    scan(mk_dr(32'h06, 32'h5555, 2'd2), c);
    chk("t2_cap_clr", c, mk_dr(32'h05, 32'h1234, 2'd0));
    serve(0, 3, 32'h0, 2'd0, 32'h06, 32'h5555, 2'd2);
    chk("t2_err_end", 64'(err_m), 64'd0);

    // Hard reset while a read waits and busy is set
    scan(mk_dr(32'h22, 32'h0, 2'd1), c);
    chk("t6_cap0", c, mk_dr(32'h06, 32'h5555, 2'd0));
    chk("t6_valid", 64'(valid_m), 64'd1);
    req_ready = 1'b1; @(negedge tck); req_ready = 1'b0;
    scan(mk_dr(32'h33, 32'hFFFF, 2'd2), c);
    chk("t6_cap_busy", c, mk_dr(32'h22, 32'h0, 2'd3));
    chk("t6_err_busy", 64'(err_m), 64'd3);
    dtmcs_write(1'b0, 1'b1);
    chk("t6_err_hard", 64'(err_m), 64'd0);
    repeat (2) @(negedge tck);
    respond(32'h77777777, 2'd0);
    scan(mk_dr(32'h0, 32'h0, 2'd0), c);
    chk("t6_cap_drained", c, mk_dr(32'h22, 32'h0, 2'd0));
    scan(mk_dr(32'h23, 32'h0, 2'd1), c);
    chk("t6_cap1", c, mk_dr(32'h0, 32'h0, 2'd0));
    serve(1, 1, 32'h12345678, 2'd0, 32'h23, 32'h0, 2'd1);
    scan(mk_dr(32'h0, 32'h0, 2'd0), c);
    chk("t6_cap_read", c, mk_dr(32'h23, 32'h12345678, 2'd0));

    // Randomized transactions against a transaction-level model
    dtmcs_write(1'b1, 1'b0);
    scan(mk_dr(32'h15, 32'hA5A5A5A5, 2'd0), c);
    m_addr = 32'h15; m_data = 32'hA5A5A5A5; m_err = 2'd0;
    @(negedge tck);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        dtmcs_write(1'b1, 1'b0);
        m_err = 2'd0;
      end
      ra  = 32'($urandom_range(0, 127));
      rw  = $urandom;
      rr  = $urandom;
      rop = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      issue = (m_err == 2'd0) && ((rop == 2'd1) || (rop == 2'd2));
      txn(ra, rw, rr, rop, rst, issue, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), c);
      chk($sformatf("rnd%0d_cap", i), c, mk_dr(m_addr, m_data, m_err));
      if (m_err == 2'd0) begin
        m_addr = ra;
        m_data = (rop == 2'd1) ? rr : rw;
        if (issue && (rst != 2'd0)) m_err = 2'd2;
      end
      chk($sformatf("rnd%0d_err", i), 64'(err_m), 64'(m_err));
    end

    // 12-bit address instance: wide DR and 16-cycle timeout
    sel = 1'b1;
    @(negedge tck);
    scan(mk_dr(32'hABC, 32'h0, 2'd1), c);
    chk("t5_cap0", c, 64'd0);
    serve(1, 2, 32'h0F0F0F0F, 2'd0, 32'hABC, 32'h0, 2'd1);
    scan(mk_dr(32'h5A5, 32'h600DCAFE, 2'd0), c);
    chk("t5_cap_read", c, mk_dr(32'hABC, 32'h0F0F0F0F, 2'd0));
    scan(mk_dr(32'h003, 32'h13579BDF, 2'd1), c);
    chk("t4_cap0", c, mk_dr(32'h5A5, 32'h600DCAFE, 2'd0));
    chk("t4_valid", 64'(valid_m), 64'd1);
    req_ready = 1'b1; @(negedge tck); req_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      chk($sformatf("t4_err_cyc%0d", i), 64'(err_m), (i < 17) ? 64'd0 : 64'd2);
      if (i < 17) @(negedge tck);
    end
    repeat (3) @(negedge tck);
    respond(32'hCAFEF00D, 2'd0);
    scan(mk_dr(32'h0, 32'h0, 2'd0), c);
    chk("t4_cap_timeout", c, mk_dr(32'h003, 32'h13579BDF, 2'd2));
    dtmcs_write(1'b1, 1'b0);
    chk("t4_err_clr", 64'(err_m), 64'd0);
    scan(mk_dr(32'h7FF, 32'h0, 2'd1), c);
    chk("t4_cap_clr", c, mk_dr(32'h003, 32'h13579BDF, 2'd0));
    serve(0, 1, 32'h44, 2'd0, 32'h7FF, 32'h0, 2'd1);
    chk("t4_err_end", 64'(err_m), 64'd0);

    // Asynchronous reset with a request pending
    sel = 1'b0;
    dtmcs_write(1'b1, 1'b0);
    scan(mk_dr(32'h44, 32'h0, 2'd1), c);
    chk("arst_valid_before", 64'(valid_a), 64'd1);
    #3 trst_n = 1'b0;
    #1 chk("arst_valid_async", 64'(valid_a), 64'd0);
    @(negedge tck);
    trst_n = 1'b1;
    @(negedge tck);
    scan(mk_dr(32'h0, 32'h0, 2'd0), c);
    chk("arst_cap_a", c, 64'd0);
    sel = 1'b1;
    scan(mk_dr(32'h0, 32'h0, 2'd0), c);
    chk("arst_cap_b", c, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
